// File: rtl/mul_share_arbiter.sv
// Shares one in-order multiplier between two requesters; a 1-bit tag FIFO routes results back.
// Define MUL_SHARE_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties (no priority pointer).
module mul_share_arbiter #(
  parameter int p_req_bits     = 110,
  parameter int p_resp_bits    = 75,
  parameter int p_max_inflight = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [p_req_bits-1:0]  req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [p_req_bits-1:0]  req1_msg,
  output logic                   mul_req_val,
  input  logic                   mul_req_rdy,
  output logic [p_req_bits-1:0]  mul_req_msg,
  input  logic                   mul_resp_val,
  output logic                   mul_resp_rdy,
  input  logic [p_resp_bits-1:0] mul_resp_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [p_resp_bits-1:0] resp0_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [p_resp_bits-1:0] resp1_msg
);
  localparam int c_ptr_bits = $clog2(p_max_inflight);
  localparam logic [c_ptr_bits:0]   c_max     = (c_ptr_bits+1)'(p_max_inflight);
  localparam logic [c_ptr_bits:0]   c_cnt_one = (c_ptr_bits+1)'(1);
  localparam logic [c_ptr_bits-1:0] c_ptr_one = c_ptr_bits'(1);

  logic                  r_tags [p_max_inflight];
  logic [c_ptr_bits-1:0] r_wptr;
  logic [c_ptr_bits-1:0] r_rptr;
  logic [c_ptr_bits:0]   r_count;

  logic w_head;
  logic w_nonempty;
  logic w_pop;
  logic w_push;
  logic w_room;
  logic w_tie_sel;
  logic w_grant0;
  logic w_grant1;

  assign w_head     = r_tags[r_rptr];
  assign w_nonempty = (r_count != '0);

  // Results go only to the port named by the oldest outstanding tag.
  always_comb begin
    mul_resp_rdy = 1'b0;
    resp0_val    = 1'b0;
    resp1_val    = 1'b0;
    if (rst && w_nonempty) begin
      mul_resp_rdy = w_head ? resp1_rdy : resp0_rdy;
      resp0_val    = mul_resp_val & ~w_head;
      resp1_val    = mul_resp_val & w_head;
    end
  end

  assign resp0_msg = mul_resp_msg;
  assign resp1_msg = mul_resp_msg;
  assign w_pop     = mul_resp_val & mul_resp_rdy;

  // A same-cycle pop frees a slot, so a full FIFO can still accept a new op.
  assign w_room = rst & mul_req_rdy & ((r_count < c_max) | w_pop);

`ifdef MUL_SHARE_ARBITER_FIXED_PRIO_EN
  assign w_tie_sel = 1'b0;
`else
  logic r_prio;

  assign w_tie_sel = r_prio;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio <= 1'b0;
    end else if (w_grant0) begin
      r_prio <= 1'b1;
    end else if (w_grant1) begin
      r_prio <= 1'b0;
    end
  end
`endif

  assign w_grant0 = w_room & req0_val & (~req1_val | ~w_tie_sel);
  assign w_grant1 = w_room & req1_val & (~req0_val | w_tie_sel);
  assign w_push   = w_grant0 | w_grant1;

  assign req0_rdy    = w_grant0;
  assign req1_rdy    = w_grant1;
  assign mul_req_val = w_push;
  assign mul_req_msg = w_grant1 ? req1_msg : req0_msg;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wptr] <= w_grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: queue-based reference model plus an in-bench 1-stage multiplier.
module tb_mul_share_arbiter;
  localparam int QB   = 110;
  localparam int PB   = 75;
  localparam int MAXF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  logic [QB-1:0] req0_msg, req1_msg, mul_req_msg;
  logic          mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [PB-1:0] mul_resp_msg, resp0_msg, resp1_msg;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;

  mul_share_arbiter #(.p_req_bits(QB), .p_resp_bits(PB), .p_max_inflight(MAXF)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus knobs
  logic        rstn;
  logic        v [2];
  logic        rr [2];
  logic        mrdy;
  logic [15:0] opa [2];
  logic [15:0] opb [2];
  logic [7:0]  seq [2];
  int          dut_g [2];

  // reference model: outstanding requester IDs in issue order, multiplier results, per-port expectations
  bit            tags_q [$];
  bit            prio;
  logic [PB-1:0] mq [$];
  logic [PB-1:0] exp_q0 [$];
  logic [PB-1:0] exp_q1 [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [QB-1:0] mk_req(input int p);
    logic [31:0] pc;
    pc = 32'h1000_0000 + 32'(p);
    return {pc, seq[p], 16'h0, opa[p], 16'h0, opb[p], (p != 0) ? 5'd2 : 5'd1, 1'b0};
  endfunction

  function automatic logic [PB-1:0] mk_resp(input logic [QB-1:0] m);
    logic [31:0] op1, op2, prod;
    op1  = m[69:38];
    op2  = m[37:6];
    prod = op1 * op2;
    return {m[106:78], m[77:70], m[5:1], prod, 1'b1};
  endfunction

  task automatic tick();
    logic [QB-1:0] m [2];
    logic [PB-1:0] e;
    bit            head, nonempty, emrr, pop, can, tie_sel, g0, g1, p;
    @(negedge clk);
    m[0] = mk_req(0);
    m[1] = mk_req(1);
    rst          = rstn;
    req0_val     = v[0];
    req1_val     = v[1];
    req0_msg     = m[0];
    req1_msg     = m[1];
    mul_req_rdy  = mrdy;
    mul_resp_val = (mq.size() != 0);
    mul_resp_msg = (mq.size() != 0) ? mq[0] : '0;
    resp0_rdy    = rr[0];
    resp1_rdy    = rr[1];
    #1;
    nonempty = (tags_q.size() != 0);
    head     = nonempty ? tags_q[0] : 1'b0;
    emrr     = rstn && nonempty && rr[head];
    pop      = mul_resp_val && emrr;
    can      = rstn && mrdy && ((tags_q.size() < MAXF) || pop);
`ifdef MUL_SHARE_ARBITER_FIXED_PRIO_EN
    tie_sel = 1'b0;
`else
    tie_sel = prio;
`endif
    g0 = can && v[0] && (!v[1] || !tie_sel);
    g1 = can && v[1] && (!v[0] || tie_sel);
    chk("req0_rdy", req0_rdy, g0);
    chk("req1_rdy", req1_rdy, g1);
    chk("mul_req_val", mul_req_val, g0 | g1);
    if (g0 | g1) chk("mul_req_msg", mul_req_msg, g1 ? m[1] : m[0]);
    chk("mul_resp_rdy", mul_resp_rdy, emrr);
    chk("resp0_val", resp0_val, rstn && mul_resp_val && nonempty && !head);
    chk("resp1_val", resp1_val, rstn && mul_resp_val && nonempty && head);
    if (req0_rdy === 1'b1) dut_g[0]++;
    if (req1_rdy === 1'b1) dut_g[1]++;
    if (pop) begin
      if (head) begin
        e = (exp_q1.size() != 0) ? exp_q1.pop_front() : '0;
        chk("resp1_order", resp1_msg, e);
      end else begin
        e = (exp_q0.size() != 0) ? exp_q0.pop_front() : '0;
        chk("resp0_order", resp0_msg, e);
      end
    end
    if (!rstn) begin
      tags_q.delete();
      mq.delete();
      exp_q0.delete();
      exp_q1.delete();
      prio = 1'b0;
    end else begin
      if (pop) begin
        void'(tags_q.pop_front());
        void'(mq.pop_front());
      end
      if (g0 | g1) begin
        p = g1;
        tags_q.push_back(p);
        mq.push_back(mk_resp(m[p]));
        if (p) exp_q1.push_back(mk_resp(m[1]));
        else   exp_q0.push_back(mk_resp(m[0]));
        seq[p] = seq[p] + 8'd1;
        prio = !p;
      end
    end
    $display("t=%0t rst=%0b v=%0b%0b g=%0b%0b pop=%0b rr=%0b%0b outstanding=%0d", $time, rstn,
             v[0], v[1], req0_rdy, req1_rdy, pop, rr[0], rr[1], tags_q.size());
    @(posedge clk);
  endtask

  initial begin
    int base;
    rst = 1'b0; req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
    mul_req_rdy = 1'b0; mul_resp_val = 1'b0; mul_resp_msg = '0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    rstn = 1'b0; prio = 1'b0;
    seq[0] = 8'd0; seq[1] = 8'd0; dut_g[0] = 0; dut_g[1] = 0;
    opa[0] = 16'd6; opb[0] = 16'd7; opa[1] = 16'd3; opb[1] = 16'd5;

    // reset with every input active: outputs must stay 0
    v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1; mrdy = 1'b1;
    repeat (3) tick();

    // round-robin tie: 6*7 to resp0, 3*5 to resp1
    rstn = 1'b1;
    repeat (8) tick();
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (4) tick();

    // credit limit, then full push+pop in one cycle
    base = dut_g[0];
    rr[0] = 1'b0; v[0] = 1'b1;
    repeat (8) tick();
    chk("credit_grants", 128'(dut_g[0] - base), 128'd4);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    chk("credit_one_more", 128'(dut_g[0] - base), 128'd5);
    repeat (3) tick();
    chk("credit_hold", 128'(dut_g[0] - base), 128'd5);
    rr[0] = 1'b1; v[0] = 1'b0;
    repeat (8) tick();

    // head ID=1 blocked by resp1_rdy=0 while resp0_rdy=1
    rr[1] = 1'b0;
    v[1] = 1'b1; repeat (2) tick();
    v[1] = 1'b0; v[0] = 1'b1; repeat (2) tick();
    v[0] = 1'b0; repeat (5) tick();
    rr[1] = 1'b1; repeat (8) tick();

    // reset with 3 ops outstanding; next tie goes to requester 0
    rr[0] = 1'b0; rr[1] = 1'b0; v[0] = 1'b1; v[1] = 1'b1;
    repeat (3) tick();
    v[0] = 1'b0; v[1] = 1'b0; tick();
    rstn = 1'b0; v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
    tick();
    rstn = 1'b1;
    base = dut_g[0];
    tick();
    chk("post_reset_tie", 128'(dut_g[0] - base), 128'd1);
    v[0] = 1'b0; v[1] = 1'b0; repeat (4) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      v[0]   = 1'($urandom_range(0, 1));
      v[1]   = 1'($urandom_range(0, 1));
      rr[0]  = ($urandom_range(0, 3) != 0);
      rr[1]  = ($urandom_range(0, 3) != 0);
      mrdy   = ($urandom_range(0, 4) != 0);
      rstn   = ($urandom_range(0, 99) != 0);
      opa[0] = 16'($urandom); opb[0] = 16'($urandom);
      opa[1] = 16'($urandom); opb[1] = 16'($urandom);
      tick();
    end
    rstn = 1'b1; v[0] = 1'b0; v[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1; mrdy = 1'b1;
    repeat (8) tick();
    chk("drained", 128'(tags_q.size()), 128'(mq.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter p_req_bits, default 110, giving the width of a D-to-X message (pc, seq_num, op1, op2, waddr, uop).
REQ-002 SHALL have parameter p_resp_bits, default 75, giving the width of an X-to-W message (pc, seq_num, waddr, wdata, wen).
REQ-003 SHALL have parameter p_max_inflight, default 4, giving the maximum number of outstanding multiplier ops; it SHALL be a power of two, at least 2.
REQ-004 Ports (clock and reset first):
- clk  input  1  clock; one clock only.
- rst  input  1  synchronous, active-low reset.
- req0_val  input  1  requester 0 has an op.
- req0_rdy  output  1  requester 0 op accepted this cycle.
- req0_msg  input  p_req_bits  requester 0 op.
- req1_val / req1_rdy / req1_msg  in/out/in  1/1/p_req_bits  same as requester 0, for requester 1.
- mul_req_val  output  1  op presented to the shared multiplier.
- mul_req_rdy  input  1  multiplier accepts.
- mul_req_msg  output  p_req_bits  granted op.
- mul_resp_val  input  1  multiplier result valid.
- mul_resp_rdy  output  1  result consumed.
- mul_resp_msg  input  p_resp_bits  multiplier result.
- resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/p_resp_bits  result routed to requester 0.
- resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/p_resp_bits  result routed to requester 1.

Function
REQ-005 SHALL keep a tag FIFO of depth p_max_inflight holding a 1-bit requester ID per accepted op, plus a count register of width clog2(p_max_inflight)+1.
REQ-006 Grant rule: the arbiter SHALL grant at most one requester per cycle. A grant requires reqN_val=1, mul_req_rdy=1, and either count<p_max_inflight or a same-cycle FIFO pop.
REQ-007 If both requesters are valid, the grant SHALL go to the requester selected by the 1-bit priority pointer.
REQ-008 After a grant, the pointer SHALL point to the non-granted requester. With no grant, the pointer SHALL be unchanged.
REQ-009 reqN_rdy SHALL equal grantN, combinationally. mul_req_val SHALL equal grant0|grant1. mul_req_msg SHALL be the granted requester's msg; it SHALL be don't-care when no grant.
REQ-010 On a grant, the granted ID SHALL be pushed to the FIFO tail in the same cycle that the mul_req handshake fires.
REQ-011 Results SHALL return from the multiplier in order. The FIFO head ID selects the destination port.
- respH_val = mul_resp_val & (count!=0), where H is the head ID.
- resp of the other port: val = 0.
- respH_msg = mul_resp_msg.
- mul_resp_rdy = respH_rdy & (count!=0).
REQ-012 A FIFO pop SHALL occur when mul_resp_val & mul_resp_rdy.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and advance both pointers. This SHALL hold when full (count=p_max_inflight) and when count=1.
REQ-014 FIFO read and write pointers SHALL wrap modulo p_max_inflight.
REQ-015 A resp_val while count=0 is illegal. It SHALL be ignored (mul_resp_rdy=0) and SHALL NOT underflow count.
REQ-016 The block SHALL add zero cycles of latency on both request and response paths; it SHALL contain no data registers.

Reset
REQ-017 While rst=0 at a clk edge: count=0, FIFO pointers=0, priority pointer=0 (requester 0 first).
REQ-018 During reset, all outputs SHALL be 0: reqN_rdy, mul_req_val, mul_resp_rdy, respN_val.
REQ-019 Reset mid-operation SHALL discard all outstanding tags. The multiplier SHALL be reset by the same rst.

Configuration
REQ-020 Macro MUL_SHARE_ARBITER_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties and the priority pointer is not implemented.
- Undefined: round-robin per REQ-007/REQ-008.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-021 Round-robin tie: req0 and req1 valid every cycle, mul_req_rdy=1, 1-stage multiplier.
- Required: grants alternate 0,1,0,1.
- Required: results 6*7=42 go to resp0 and 3*5=15 go to resp1, in issue order.
REQ-022 Credit limit: p_max_inflight=4, resp0_rdy=0, req0 continuously valid.
- Required: exactly 4 grants, then req0_rdy=0.
- Required: raising resp0_rdy for one cycle allows exactly one new grant in that same cycle.
REQ-023 Full push/pop: count=4, with a result pop and a new request in the same cycle.
- Required: grant occurs, count stays 4, and the next routed result belongs to the oldest op.
REQ-024 Backpressure: resp1_rdy=0 while head ID=1 and resp0_rdy=1.
- Required: resp0_val=0 and mul_resp_rdy=0 until resp1_rdy=1.
- Required: seq_nums then arrive in order.
REQ-025 Reset mid-run: rst=0 for one cycle with 3 ops outstanding.
- Required: all outputs 0, count=0, and the next tie grants requester 0.
REQ-026 Fixed-priority build: with MUL_SHARE_ARBITER_FIXED_PRIO_EN defined and both requesters always valid, requester 0 is granted every cycle and req1_rdy stays 0.
